pw_lock_multi: RTL

Parametrised multi-slot password lock controller, the next generation of the ChipInterface lock FSM. It accepts debounced button levels (enter0/enter1/confirm/clear/change_pw), checks the entered bit string against one of NUM_SLOTS stored passwords, and enforces a tick-timed pass/fail display and escalating lockout. It adds runtime password change with double-entry verification. It sits directly under the chip top, replacing the fixed-width single-password FSM.

---
 rtl/pw_lock_multi_if.sv | 35 +++
 rtl/pw_lock_multi.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pw_lock_multi_if.sv
// Button/status bundle between the chip top and the
// multi-slot password lock.
interface pw_lock_multi_if #(
  parameter int PW_LEN    = 6,
  parameter int NUM_SLOTS = 2
);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(PW_LEN + 2);

  logic          enter0;
  logic          enter1;
  logic          confirm;
  logic          clear;
  logic          change_pw;
  logic [SW-1:0] slot_sel;
  logic [2:0]    state;
  logic          unlocked;
  logic          alarm;
  logic          locked;
  logic [CW-1:0] digit_cnt;
  logic [2:0]    fail_cnt;
  logic          pw_updated;

  modport master (
    output enter0, enter1, confirm, clear, change_pw, slot_sel,
    input  state, unlocked, alarm, locked,
    input  digit_cnt, fail_cnt, pw_updated
  );

  modport slave (
    input  enter0, enter1, confirm, clear, change_pw, slot_sel,
    output state, unlocked, alarm, locked,
    output digit_cnt, fail_cnt, pw_updated
  );
endinterface

// File: rtl/pw_lock_multi.sv
// Multi-slot password lock: tick-timed pass/fail display,
// escalating lockout and double-entry password change.
module pw_lock_multi #(
  parameter int FRE             = 6,
  parameter int PW_LEN          = 6,
  parameter int NUM_SLOTS       = 2,
  parameter logic [NUM_SLOTS*PW_LEN-1:0] DEFAULT_PW =
    {6'b110100, 6'b101101},
  parameter int IDLE_TICKS      = 60,
  parameter int PASS_TICKS      = 6,
  parameter int FAIL_TICKS      = 6,
  parameter int LOCK_BASE_TICKS = 15,
  parameter int LOCK_MAX_EXP    = 2
) (
  input  logic           clock,
  input  logic           reset,
  pw_lock_multi_if.slave bus
);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(PW_LEN + 2);
  localparam int DW = $clog2(FRE);
  localparam int LW = $clog2(LOCK_BASE_TICKS) + LOCK_MAX_EXP + 1;
  localparam int TW = (LW > 16) ? LW : 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4,
    S_LOCK  = 3'd5,
    S_NEW1  = 3'd6,
    S_NEW2  = 3'd7
  } state_t;

  state_t state, state_n;

  logic [4:0] btn, btn_q, rise, press;
  logic       p_dig;
  logic [DW-1:0] div;
  logic [TW-1:0] tmr, lim;
  logic       tick, expire;
  logic [PW_LEN-1:0] pw_buf, cand, slot_val;
  logic [CW-1:0] cnt;
  logic [NUM_SLOTS*PW_LEN-1:0] slots;
  logic [SW-1:0] chk_slot;
  logic [2:0] fail_cnt, fc_m1;
  logic [LW-1:0] lock_ticks;
  logic       full, slot_ok, match, upd_q, clr_entry;
  logic       dig_en, clr_en, kick, slot_ld, cand_ld, wr_en;

  assign btn = {bus.change_pw, bus.clear, bus.confirm,
                bus.enter1, bus.enter0};
  assign rise = btn & ~btn_q;
  // Simultaneous presses cancel each other out.
  assign press = ((rise & (rise - 5'd1)) == 5'd0) ? rise : 5'd0;
  assign p_dig = press[0] | press[1];

  assign tick = (div == DW'(FRE - 1));

  assign fc_m1 = (fail_cnt == 3'd0) ? 3'd0 : fail_cnt - 3'd1;
  assign lock_ticks = (int'(fc_m1) > LOCK_MAX_EXP)
    ? (LW'(LOCK_BASE_TICKS) << LOCK_MAX_EXP)
    : (LW'(LOCK_BASE_TICKS) << fc_m1);

  always_comb begin
    lim = TW'(IDLE_TICKS);
    case (state)
      S_PASS:  lim = TW'(PASS_TICKS);
      S_FAIL:  lim = TW'(FAIL_TICKS);
      S_LOCK:  lim = TW'(lock_ticks);
      default: ;
    endcase
  end

  assign expire = tick && (tmr == lim - 1'b1);

  always_comb begin
    slot_val = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (chk_slot == SW'(i))
        slot_val = slots[i*PW_LEN +: PW_LEN];
  end

  assign full    = (cnt == CW'(PW_LEN));
  assign slot_ok = (int'(chk_slot) < NUM_SLOTS);
  assign match   = full && slot_ok && (pw_buf == slot_val);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    dig_en  = 1'b0;
    clr_en  = 1'b0;
    kick    = 1'b0;
    slot_ld = 1'b0;
    cand_ld = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      S_IDLE:
        if (p_dig) begin
          state_n = S_ENTRY;
          dig_en  = 1'b1;
        end
      S_ENTRY, S_NEW1, S_NEW2:
        unique case (1'b1)
          p_dig: begin
            dig_en = 1'b1;
            kick   = 1'b1;
          end
          press[3]: begin
            clr_en = 1'b1;
            kick   = 1'b1;
          end
          press[2]:
            if (state == S_ENTRY) begin
              state_n = S_CHECK;
              slot_ld = 1'b1;
            end else if (state == S_NEW1) begin
              cand_ld = full;
              state_n = full ? S_NEW2 : S_IDLE;
            end else begin
              wr_en   = full && (pw_buf == cand);
              state_n = S_IDLE;
            end
          default:
            if (expire) state_n = S_IDLE;
        endcase
      S_CHECK: state_n = match ? S_PASS : S_FAIL;
      S_PASS:
        if (press[4])    state_n = S_NEW1;
        else if (expire) state_n = S_IDLE;
      S_FAIL: if (expire) state_n = S_LOCK;
      S_LOCK: if (expire) state_n = S_IDLE;
    endcase
  end

  assign clr_entry = (state_n != state) &&
    (state_n inside {S_IDLE, S_PASS, S_NEW1, S_NEW2, S_FAIL});

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_q    <= btn;
      div      <= '0;
      tmr      <= '0;
      pw_buf   <= '0;
      cnt      <= '0;
      cand     <= '0;
      slots    <= DEFAULT_PW;
      chk_slot <= '0;
      fail_cnt <= '0;
      upd_q    <= 1'b0;
    end else begin
      btn_q <= btn;
      upd_q <= wr_en;
      if ((state_n != state) || kick) begin
        div <= '0;
        tmr <= '0;
      end else if (tick) begin
        div <= '0;
        tmr <= tmr + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
      if (clr_entry || clr_en) begin
        pw_buf <= '0;
        cnt    <= '0;
      end else if (dig_en) begin
        pw_buf <= {pw_buf[PW_LEN-2:0], press[1]};
        cnt    <= (cnt >= CW'(PW_LEN)) ? CW'(PW_LEN + 1)
                                       : cnt + 1'b1;
      end
      if (slot_ld) chk_slot <= bus.slot_sel;
      if (cand_ld)               cand <= pw_buf;
      else if (state_n == S_IDLE) cand <= '0;
      if (state == S_CHECK)
        fail_cnt <= match ? 3'd0
                  : (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;
      if (wr_en)
        for (int i = 0; i < NUM_SLOTS; i++)
          if (chk_slot == SW'(i))
            slots[i*PW_LEN +: PW_LEN] <= cand;
    end
  end

  assign bus.state      = state;
  assign bus.unlocked   = (state == S_PASS);
  assign bus.alarm      = (state == S_FAIL);
  assign bus.locked     = (state == S_LOCK);
  assign bus.digit_cnt  = cnt;
  assign bus.fail_cnt   = fail_cnt;
  assign bus.pw_updated = upd_q;
endmodule
